// File: rtl/sm_to_fp_pkg.sv
// sm_to_fp_pkg: widths, exponent limit and FSM encoding shared by the
// sign-magnitude to 8-bit float encoder.
package sm_to_fp_pkg;
  localparam int MAG_W = 11;
  localparam int EXP_W = 3;
  localparam int SIG_W = 4;
  localparam int EMAX  = 6;
  localparam int R_W   = MAG_W - 1;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/sm_to_fp_round.sv
// sm_to_fp_round: round-half-up of the normalised top bits, with carry into
// the exponent and saturation when the magnitude overflowed.
module sm_to_fp_round
  import sm_to_fp_pkg::*;
(
  input  logic [SIG_W:0]   i_rtop,
  input  logic [EXP_W-1:0] i_exp,
  input  logic             i_ovf,
  output logic [EXP_W-1:0] o_exp,
  output logic [SIG_W-1:0] o_sig
);
  logic [SIG_W:0] w_sum;
  logic           w_carry;
  // i_rtop[0] is the round bit sitting just below the significand
  assign w_sum   = {1'b0, i_rtop[SIG_W:1]} + {{SIG_W{1'b0}}, i_rtop[0]};
  assign w_carry = w_sum[SIG_W];
  assign o_exp   = i_ovf ? '1 : i_exp + {{(EXP_W-1){1'b0}}, w_carry};
  assign o_sig   = i_ovf ? '1 : w_carry ? {1'b1, {(SIG_W-1){1'b0}}} : w_sum[SIG_W-1:0];
endmodule

// File: rtl/sm_to_fp.sv
// sm_to_fp: encodes {sign, 11-bit magnitude} as 8-bit float {S, E[2:0], F[3:0]}
// with one normalising shift per clock, a rounding cycle and valid/ready on both sides.
module sm_to_fp
  import sm_to_fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W-1:0] in_sm,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [SIG_W-1:0] out_sig,
  output logic             busy
);
  state_t           r_state;
  logic [R_W-1:0]   r_mag;
  logic [EXP_W-1:0] r_exp;
  logic             r_sign;
  logic             r_ovf;
  logic [EXP_W-1:0] w_exp;
  logic [SIG_W-1:0] w_sig;
  assign in_ready = (r_state == IDLE) && !rst;
  assign busy     = (r_state == NORM) || (r_state == ROUND);
  sm_to_fp_round u_round (
    .i_rtop (r_mag[R_W-1:R_W-SIG_W-1]),
    .i_exp  (r_exp),
    .i_ovf  (r_ovf),
    .o_exp  (w_exp),
    .o_sig  (w_sig)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mag     <= '0;
      r_exp     <= '0;
      r_sign    <= 1'b0;
      r_ovf     <= 1'b0;
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_sig   <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_mag   <= in_sm[R_W-1:0];
          r_sign  <= in_sign;
          r_exp   <= EXP_W'(EMAX);
          r_ovf   <= in_sm[MAG_W-1];
          r_state <= NORM;
        end
        NORM: if (!r_mag[R_W-1] && r_exp != '0) begin
          r_mag <= {r_mag[R_W-2:0], 1'b0};
          r_exp <= r_exp - EXP_W'(1);
        end else begin
          r_state <= ROUND;
        end
        ROUND: begin
          out_sign  <= r_sign;
          out_exp   <= w_exp;
          out_sig   <= w_sig;
          out_valid <= 1'b1;
          r_state   <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end
endmodule
